writeback_regfile: RTL



---
 rtl/mips_pkg.sv | 18 +
 rtl/regfile_core.sv | 41 ++++
 rtl/writeback_regfile.sv | 64 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core constants and the MEM/WB record type.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  reg_write;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     ALU_result;
    logic [REG_ADDR_W-1:0] reg_address;
    logic                  jump_reg;
    logic                  mem_load;
  } wb_rec_t;

endpackage

// File: rtl/regfile_core.sv
// Architectural register file: r0 hardwired to zero, one write port, two async read ports.
// Define WB_BYPASS_EN for write-first forwarding of the incoming write to the read ports.
module regfile_core #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  // r0 has no storage; index range starts at 1
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) regs[ADDR_W'(i)] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != '0) rdata_a = regs[raddr_a];
    if (raddr_b != '0) rdata_b = regs[raddr_b];
`ifdef WB_BYPASS_EN
    if (we && !rst && (waddr != '0) && (raddr_a == waddr)) rdata_a = wdata;
    if (we && !rst && (waddr != '0) && (raddr_b == waddr)) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/writeback_regfile.sv
// MIPS writeback stage: selects load/ALU value, commits it to the register file, counts retired writes.
// WB_BYPASS_EN enables same-cycle write-to-read forwarding inside regfile_core.
module writeback_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reg_write,
  input  logic [DATA_W-1:0]           data,
  input  logic [DATA_W-1:0]           ALU_result,
  input  logic [$clog2(NUM_REGS)-1:0] reg_address,
  input  logic                        jump_reg,
  input  logic                        mem_load,
  input  logic [$clog2(NUM_REGS)-1:0] read_addr_a,
  input  logic [$clog2(NUM_REGS)-1:0] read_addr_b,
  output logic [DATA_W-1:0]           read_data_a,
  output logic [DATA_W-1:0]           read_data_b,
  output logic [DATA_W-1:0]           wb_data,
  output logic [31:0]                 wb_count
);

  import mips_pkg::*;

  wb_rec_t     rec;
  logic        we;
  logic [31:0] count_q;

  always_comb begin
    rec.reg_write   = reg_write;
    rec.data        = data;
    rec.ALU_result  = ALU_result;
    rec.reg_address = reg_address;
    rec.jump_reg    = jump_reg;
    rec.mem_load    = mem_load;
  end

  assign wb_data = rec.mem_load ? rec.data : rec.ALU_result;
  assign we      = rec.reg_write && !rec.jump_reg && (rec.reg_address != REG_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   count_q <= '0;
    else if (we) count_q <= count_q + 32'd1;
  end

  assign wb_count = count_q;

  regfile_core #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   ($clog2(NUM_REGS))
  ) u_core (
    .clk     (clk),
    .rst     (reset),
    .we      (we),
    .waddr   (rec.reg_address),
    .wdata   (wb_data),
    .raddr_a (read_addr_a),
    .raddr_b (read_addr_b),
    .rdata_a (read_data_a),
    .rdata_b (read_data_b)
  );

endmodule
